// File: rtl/noc_nexthop_pkg.sv
// Shared next-hop codes and grant FSM state type for the NoC output port.
package noc_nexthop_pkg;

  localparam logic [2:0] NH_IDLE     = 3'b001;
  localparam logic [2:0] NH_REQ_BASE = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } nh_state_e;

  // Requester k is announced to the next-hop register as NH_REQ_BASE + k.
  function automatic logic [2:0] nh_req_code(input int unsigned k);
    return NH_REQ_BASE + 3'(k);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IW'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nexthop_grant_fsm.sv
// Output-port grant FSM: round-robin packet grant, flit countdown and next-hop register strobes.
module nexthop_grant_fsm
  import noc_nexthop_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*LEN_W-1:0] head_len_i,
  input  logic                     flit_sent_i,
  output logic                     nhr_write_o,
  output logic [2:0]               nhr_address_o,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic                     pt_almost_done_o,
  output logic                     ib_empty_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  nh_state_e          state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [NUM_REQ-1:0] grant_d;
  logic               nhr_write_d;
  logic [2:0]         nhr_address_d;
  logic               ib_empty_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic [LEN_W-1:0]   win_len;
  logic               go_done;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) u_rr_picker (
    .req  (req_i),
    .ptr  (rr_ptr_q),
    .grant(pick_grant),
    .idx  (pick_idx)
  );

  always_comb begin
    win_len = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == IW'(k)) win_len = head_len_i[k*LEN_W +: LEN_W];
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    win_d         = win_q;
    remaining_d   = remaining_q;
    grant_d       = grant_o;
    nhr_write_d   = 1'b0;
    nhr_address_d = nhr_address_o;
    ib_empty_d    = 1'b0;
    go_done       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          state_d       = ST_XFER;
          grant_d       = pick_grant;
          win_d         = pick_idx;
          remaining_d   = (win_len == '0) ? LEN_W'(1) : win_len;
          nhr_write_d   = 1'b1;
          nhr_address_d = nh_req_code(32'(pick_idx));
        end
      end
      ST_XFER: begin
        // Last flit wins over a simultaneous request drop: that is a clean finish.
        if (flit_sent_i && remaining_q == LEN_W'(1)) begin
          go_done = 1'b1;
        end else if (!req_i[win_q]) begin
          go_done    = 1'b1;
          ib_empty_d = 1'b1;
        end else if (flit_sent_i) begin
          remaining_d = remaining_q - 1'b1;
        end
        if (go_done) begin
          state_d       = ST_DONE;
          grant_d       = '0;
          remaining_d   = '0;
          nhr_write_d   = 1'b1;
          nhr_address_d = NH_IDLE;
          rr_ptr_d      = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      win_q         <= '0;
      remaining_q   <= '0;
      grant_o       <= '0;
      nhr_write_o   <= 1'b0;
      nhr_address_o <= NH_IDLE;
      ib_empty_o    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      win_q         <= win_d;
      remaining_q   <= remaining_d;
      grant_o       <= grant_d;
      nhr_write_o   <= nhr_write_d;
      nhr_address_o <= nhr_address_d;
      ib_empty_o    <= ib_empty_d;
    end
  end

  assign pt_almost_done_o = (state_q == ST_XFER) && (remaining_q == LEN_W'(1));

endmodule

// File: tb/tb_nexthop_grant_fsm.sv
// Self-checking bench for nexthop_grant_fsm: directed packets plus randomized traffic vs a packet-level model.
module tb_nexthop_grant_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_i;
  logic [15:0] head_len_i;
  logic        flit_sent_i;
  logic        nhr_write_o;
  logic [2:0]  nhr_address_o;
  logic [3:0]  grant_o;
  logic        pt_almost_done_o;
  logic        ib_empty_o;

  int n_checks = 0;
  int n_errors = 0;
  int m_ptr    = 0;
  int pkt_len[4];

  always #5 clk = ~clk;

  nexthop_grant_fsm #(.NUM_REQ(4), .LEN_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_i           (req_i),
    .head_len_i      (head_len_i),
    .flit_sent_i     (flit_sent_i),
    .nhr_write_o     (nhr_write_o),
    .nhr_address_o   (nhr_address_o),
    .grant_o         (grant_o),
    .pt_almost_done_o(pt_almost_done_o),
    .ib_empty_o      (ib_empty_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick_model(input logic [3:0] mask, input int ptr);
    int k;
    for (int i = 0; i < 4; i++) begin
      k = (ptr + i) % 4;
      if (mask[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [15:0] pack_lens();
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v = v | (16'(pkt_len[k] & 15) << (4 * k));
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_grant"}, 32'(grant_o), 0);
    check_eq({tag, "_wr"}, 32'(nhr_write_o), 0);
    check_eq({tag, "_addr"}, 32'(nhr_address_o), 1);
    check_eq({tag, "_pt"}, 32'(pt_almost_done_o), 0);
    check_eq({tag, "_ib"}, 32'(ib_empty_o), 0);
  endtask

  // Called at a negedge with the DUT idle (or finishing); drives one packet to completion.
  task automatic run_pkt(input logic [3:0] mask, input int drop_at);
    int w, rem, sent, cyc;
    bit got, done, exp_ib, flit;
    w = pick_model(mask, m_ptr);
    req_i = mask;
    head_len_i = pack_lens();
    flit_sent_i = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 4 && !got; c++) begin
      @(negedge clk);
      got = (grant_o != 4'b0000);
    end
    if (!got) begin
      check_eq("grant_timeout", 0, 1);
      return;
    end
    check_eq("grant", 32'(grant_o), 32'(1) << w);
    check_eq("grant_wr", 32'(nhr_write_o), 1);
    check_eq("grant_addr", 32'(nhr_address_o), 32'(2 + w));
    rem = (pkt_len[w] == 0) ? 1 : pkt_len[w];
    sent = 0; cyc = 0; done = 1'b0; exp_ib = 1'b0;
    while (!done && cyc < 64) begin
      if (cyc != 0) begin
        check_eq("xfer_wr", 32'(nhr_write_o), 0);
        check_eq("xfer_grant", 32'(grant_o), 32'(1) << w);
      end
      check_eq("pt_almost", 32'(pt_almost_done_o), 32'(rem == 1));
      flit = ($urandom_range(0, 2) != 0) || (cyc > 30);
      if (drop_at >= 0 && sent == drop_at) begin
        req_i[w] = 1'b0;
        exp_ib = !(flit && rem == 1);
        if (exp_ib) done = 1'b1;
      end
      flit_sent_i = flit;
      if (!exp_ib && flit) begin
        rem--;
        sent++;
        if (rem == 0) done = 1'b1;
      end
      @(negedge clk);
      flit_sent_i = 1'b0;
      cyc++;
    end
    if (!done) check_eq("xfer_timeout", 0, 1);
    check_eq("done_grant", 32'(grant_o), 0);
    check_eq("done_wr", 32'(nhr_write_o), 1);
    check_eq("done_addr", 32'(nhr_address_o), 1);
    check_eq("done_ib", 32'(ib_empty_o), 32'(exp_ib));
    check_eq("done_pt", 32'(pt_almost_done_o), 0);
    m_ptr = (w + 1) % 4;
    req_i = mask;
    @(negedge clk);
    check_idle_outputs("gap");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req_i = '0;
    head_len_i = '0;
    flit_sent_i = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    // Single request, length 3.
    pkt_len = '{0, 0, 3, 0};
    run_pkt(4'b0100, -1);

    // Fairness with all requests held, all length 1.
    pkt_len = '{1, 1, 1, 1};
    m_ptr = 3;
    for (int i = 0; i < 5; i++) run_pkt(4'b1111, -1);

    // Zero length treated as one flit.
    pkt_len = '{0, 0, 0, 0};
    run_pkt(4'b0010, -1);

    // Drop mid-packet, then the pointer must sit at requester 3.
    pkt_len = '{1, 1, 5, 1};
    run_pkt(4'b0100, 2);
    run_pkt(4'b1111, -1);

    // Stray flits while idle.
    req_i = '0;
    for (int i = 0; i < 4; i++) begin
      flit_sent_i = 1'b1;
      @(negedge clk);
      check_idle_outputs("stray");
    end
    flit_sent_i = 1'b0;

    // Reset mid-transfer; pointer first moved away from 0.
    pkt_len = '{1, 4, 1, 1};
    run_pkt(4'b0001, -1);
    req_i = 4'b0010;
    head_len_i = pack_lens();
    @(negedge clk);
    check_eq("pre_rst_grant", 32'(grant_o), 2);
    flit_sent_i = 1'b1;
    @(negedge clk);
    flit_sent_i = 1'b0;
    #2 reset = 1'b0;
    #1 check_idle_outputs("async_rst");
    @(negedge clk);
    reset = 1'b1;
    m_ptr = 0;
    run_pkt(4'b1001, -1);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      logic [3:0] mask;
      int drop_at;
      mask = 4'($urandom_range(1, 15));
      for (int k = 0; k < 4; k++) pkt_len[k] = $urandom_range(0, 6);
      drop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
      run_pkt(mask, drop_at);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nexthop_grant_fsm.md
NEXTHOP_GRANT_FSM -- requirements
Module: nexthop_grant_fsm

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of input-buffer requesters.
REQ-002 SHALL have parameter LEN_W, default 4: packet-length field width in flits.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_i, input, NUM_REQ: per-buffer head-flit request for this output.
REQ-006 SHALL have port head_len_i, input, NUM_REQ*LEN_W: packed packet lengths, slice k belongs to requester k.
REQ-007 SHALL have port flit_sent_i, input, 1: one flit of the granted packet left this cycle.
REQ-008 SHALL have port nhr_write_o, output, 1: one-cycle write strobe to the next-hop register.
REQ-009 SHALL have port nhr_address_o, output, 3: next-hop code written with nhr_write_o.
REQ-010 SHALL have port grant_o, output, NUM_REQ: one-hot grant, all-zero when idle.
REQ-011 SHALL have port pt_almost_done_o, output, 1: last flit of the current packet pending.
REQ-012 SHALL have port ib_empty_o, output, 1: granted requester dropped its request mid-packet.

Function
REQ-013 SHALL encode next-hop codes: NH_IDLE=3'b001, requester k = 3'b010+k (k=0..3).
REQ-014 SHALL implement FSM states IDLE, XFER, DONE.
REQ-015 In IDLE with req_i!=0, SHALL select the winner round-robin, searching upward from rr_ptr with wrap, and enter XFER next cycle.
REQ-016 In IDLE with req_i==0, SHALL remain in IDLE.
REQ-017 On IDLE->XFER, SHALL register grant_o one-hot for the winner, latch remaining = winner's head_len_i (0 treated as 1), and drive nhr_write_o=1 with nhr_address_o=winner code for exactly the first XFER cycle.
REQ-018 In XFER, SHALL decrement remaining on each flit_sent_i; flit_sent_i outside XFER SHALL be ignored.
REQ-019 pt_almost_done_o SHALL equal (state==XFER && remaining==1), decoded from registers.
REQ-020 flit_sent_i while remaining==1 SHALL move XFER->DONE.
REQ-021 If req_i[winner] deasserts in XFER before the last flit, SHALL assert ib_empty_o for one cycle and move to DONE; if flit_sent_i coincides with the last flit, normal completion applies, with no ib_empty_o.
REQ-022 In DONE (one cycle), SHALL clear grant_o, pulse nhr_write_o with NH_IDLE, set rr_ptr = winner+1 mod NUM_REQ, then return to IDLE.
REQ-023 Requests arriving in XFER or DONE SHALL wait; minimum gap between two grants is 2 cycles (DONE, IDLE).
REQ-024 nhr_address_o SHALL hold the last written code between strobes.
REQ-025 All outputs SHALL be registered, except pt_almost_done_o, which is a decode of registers only.

Reset
REQ-026 While reset==0, SHALL asynchronously force: state=IDLE, rr_ptr=0, remaining=0, grant_o=0, nhr_write_o=0, nhr_address_o=NH_IDLE, pt_almost_done_o=0, ib_empty_o=0.
REQ-027 Reset asserted mid-XFER SHALL abandon the packet with no DONE strobe; the first grant after release SHALL start search at requester 0.

Structure
REQ-028 SHALL place NH_IDLE, the requester code base, and the FSM state typedef in shared package noc_nexthop_pkg.
REQ-029 SHALL instantiate one sub-module, rr_picker: combinational round-robin one-hot picker (req, ptr -> grant, index).

Verification
REQ-030 Single request: req_i=4'b0100, len=3, three flit_sent_i pulses -> strobe addr 3'b100 in first XFER cycle; pt_almost_done_o high after second flit; DONE strobe 3'b001; grant_o cleared.
REQ-031 Fairness: req_i=4'b1111 held, all len=1 -> grant order 0,1,2,3,0; each grant's strobe address 3'b010,011,100,101.
REQ-032 Zero length: len=0 on requester 1 -> treated as 1; pt_almost_done_o high in first XFER cycle; one flit_sent_i completes.
REQ-033 Drop: req 2, len=5, deassert req_i[2] after 2 flits -> ib_empty_o one-cycle pulse, DONE strobe NH_IDLE, rr_ptr=3.
REQ-034 Reset mid-XFER: assert reset during len=4 packet -> outputs at reset values immediately (async); after release with req_i=4'b1001, requester 0 granted.
REQ-035 Stray flit: flit_sent_i pulses in IDLE -> no state change, no strobe.
